ifetch: RTL and testbench

- Instruction fetch stage, directly downstream of the PC register.
- Takes the current `pc` and fetches one 32-bit instruction over a req/gnt/rvalid instruction-memory bus.
- Presents the instruction, its PC and a fault flag to decode with a valid/ready handshake.
- Drives `stall` back to the PC/control so the PC does not advance while a fetch is outstanding; supports flush on redirect (jal/branch/jalr).

---
 rtl/ifetch_pkg.sv | 21 ++
 rtl/ifetch.sv | 143 ++++++++++++++
 tb/tb_ifetch.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

    // Canonical RISC-V NOP (addi x0,x0,0), substituted for faulting fetches.
    localparam logic [31:0] NOP_INSTR_WORD = 32'h0000_0013;

    // Fetch FSM states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        VALID = 3'd3,
        DROP  = 3'd4
    } fetch_state_e;

    // A fetch address is usable on the bus only if it is word aligned.
    function automatic logic is_word_aligned(input logic [1:0] lsbs);
        return (lsbs == 2'b00);
    endfunction

endpackage

// File: rtl/ifetch.sv
// Instruction fetch stage: launches one imem transaction per fetch request,
// holds the result for decode behind a valid/ready handshake, stalls the PC
// while a fetch is outstanding and discards responses after a redirect.
module ifetch #(
    parameter int unsigned            XLEN      = 32,
    parameter logic [XLEN-1:0]        NOP_INSTR = XLEN'(ifetch_pkg::NOP_INSTR_WORD)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    input  logic            fetch_en,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_fault,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic            stall
);

    import ifetch_pkg::*;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            flush_q, flush_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            instr_fault_q, instr_fault_d;
    logic            redirect_seen;

    // A redirect seen now or during an earlier REQ cycle poisons the transaction.
    assign redirect_seen = flush | flush_q;

    // Next-state and next-register computation for the fetch FSM.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        flush_d       = flush_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_fault_d = instr_fault_q;

        case (state_q)
            IDLE: begin
                if (fetch_en && !flush) begin
                    if (is_word_aligned(pc[1:0])) begin
                        addr_d  = pc;
                        state_d = REQ;
                    end else begin
                        instr_pc_d    = pc;
                        instr_d       = NOP_INSTR;
                        instr_fault_d = 1'b1;
                        state_d       = VALID;
                    end
                end
            end

            REQ: begin
                // The request cannot be withdrawn, so a redirect is only
                // remembered here and acted on once the grant arrives.
                if (flush) begin
                    flush_d = 1'b1;
                end
                if (imem_gnt) begin
                    state_d = redirect_seen ? DROP : WAIT;
                end
            end

            WAIT: begin
                if (imem_rvalid) begin
                    if (redirect_seen) begin
                        state_d = IDLE;
                    end else begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = addr_q;
                        instr_fault_d = 1'b0;
                        state_d       = VALID;
                    end
                end else if (flush) begin
                    state_d = DROP;
                end
            end

            DROP: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end

            VALID: begin
                if (instr_ready || flush) begin
                    instr_fault_d = 1'b0;
                    state_d       = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // The sticky redirect flag never survives into a new transaction.
        if (state_d == IDLE) begin
            flush_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            flush_q       <= 1'b0;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= '0;
            instr_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            flush_q       <= flush_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_fault_q <= instr_fault_d;
        end
    end

    // Bus and decode-facing outputs decoded from the registered state.
    always_comb begin
        imem_req    = (state_q == REQ);
        imem_addr   = addr_q;
        instr       = instr_q;
        instr_pc    = instr_pc_q;
        instr_fault = instr_fault_q;
        instr_valid = (state_q == VALID);
        stall       = fetch_en & ~((state_q == VALID) & instr_ready);
    end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for the instruction fetch stage.
module tb_ifetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        fetch_en;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;
    logic        instr_valid;
    logic        instr_ready;
    logic        stall;

    int vec_count  = 0;
    int fail_count = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        int          gnt_delay;
        int          rvalid_delay;
        int          hold;
        logic [31:0] exp_instr;
        logic        exp_fault;
    } fetch_vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } expect_t;

    expect_t    sb_queue[$];
    fetch_vec_t vecs[7];

    ifetch dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .fetch_en    (fetch_en),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_fault (instr_fault),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .stall       (stall)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the bench itself goes astray.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    // Wait for the held instruction, compare it with the scoreboard, apply
    // backpressure for 'hold' cycles, then hand it to decode.
    task automatic drainOutput(input int hold);
        expect_t e;
        int      n;
        n = 0;
        @(negedge clk);
        while (!instr_valid && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        checkOutput("latency", n, 0);
        checkOutput("valid_seen", instr_valid, 1'b1);
        checkOutput("sb_depth", sb_queue.size(), 1);
        if (!instr_valid || sb_queue.size() == 0) begin
            fetch_en = 1'b0;
            sb_queue.delete();
            return;
        end
        e = sb_queue.pop_front();
        checkOutput("instr", instr, e.instr);
        checkOutput("instr_pc", instr_pc, e.pc);
        checkOutput("instr_fault", instr_fault, e.fault);
        checkOutput("stall_valid", stall, 1'b1);
        checkOutput("req_in_valid", imem_req, 1'b0);
        for (int i = 0; i < hold; i++) begin
            tick();
            @(negedge clk);
            checkOutput("hold_valid", instr_valid, 1'b1);
            checkOutput("hold_instr", instr, e.instr);
            checkOutput("hold_pc", instr_pc, e.pc);
            checkOutput("hold_stall", stall, 1'b1);
            checkOutput("hold_req", imem_req, 1'b0);
        end
        instr_ready = 1'b1;
        #1;
        checkOutput("stall_release", stall, 1'b0);
        tick();
        instr_ready = 1'b0;
        fetch_en    = 1'b0;
        @(negedge clk);
        checkOutput("valid_drop", instr_valid, 1'b0);
        checkOutput("fault_clear", instr_fault, 1'b0);
    endtask

    // Launch one fetch and play the bus side with the requested delays.
    task automatic applyStimulus(input fetch_vec_t v);
        pc          = v.pc;
        fetch_en    = 1'b1;
        instr_ready = 1'b0;
        sb_queue.push_back('{v.exp_instr, v.pc, v.exp_fault});
        #1;
        checkOutput("stall_launch", stall, 1'b1);
        tick();
        if (v.pc[1:0] == 2'b00) begin
            for (int i = 0; i < v.gnt_delay; i++) begin
                @(negedge clk);
                checkOutput("req_wait", imem_req, 1'b1);
                checkOutput("addr_wait", imem_addr, v.pc);
                checkOutput("stall_req", stall, 1'b1);
                tick();
            end
            imem_gnt = 1'b1;
            @(negedge clk);
            checkOutput("req_gnt", imem_req, 1'b1);
            checkOutput("addr_gnt", imem_addr, v.pc);
            tick();
            imem_gnt = 1'b0;
            for (int i = 0; i < v.rvalid_delay; i++) begin
                @(negedge clk);
                checkOutput("req_after_gnt", imem_req, 1'b0);
                checkOutput("stall_wait", stall, 1'b1);
                tick();
            end
            imem_rvalid = 1'b1;
            imem_rdata  = v.rdata;
            tick();
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end else begin
            @(negedge clk);
            checkOutput("misaligned_no_req", imem_req, 1'b0);
        end
        drainOutput(v.hold);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0100, 32'h0050_0093, 0, 0, 0, 32'h0050_0093, 1'b0};
        vecs[1] = '{32'h0000_0104, 32'h00A0_0113, 2, 1, 5, 32'h00A0_0113, 1'b0};
        vecs[2] = '{32'h0000_0102, 32'hFFFF_FFFF, 0, 0, 0, NOP,           1'b1};
        vecs[3] = '{32'h0000_0203, 32'h1111_1111, 0, 0, 2, NOP,           1'b1};
        vecs[4] = '{32'hFFFF_FFFC, 32'h1234_5678, 1, 3, 1, 32'h1234_5678, 1'b0};
        vecs[5] = '{32'h0000_0001, 32'h0000_0000, 0, 0, 0, NOP,           1'b1};
        vecs[6] = '{32'h0000_0108, 32'hFEDC_BA98, 3, 0, 0, 32'hFEDC_BA98, 1'b0};

        rst         = 1'b1;
        pc          = '0;
        fetch_en    = 1'b0;
        flush       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_req", imem_req, 1'b0);
        checkOutput("rst_addr", imem_addr, 32'h0);
        checkOutput("rst_instr", instr, NOP);
        checkOutput("rst_instr_pc", instr_pc, 32'h0);
        checkOutput("rst_fault", instr_fault, 1'b0);
        checkOutput("rst_valid", instr_valid, 1'b0);
        checkOutput("rst_stall", stall, 1'b0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
        end

        // Redirect while waiting for data: the response must be swallowed.
        tick();
        pc       = 32'h0000_0300;
        fetch_en = 1'b1;
        tick();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        flush    = 1'b1;
        fetch_en = 1'b0;
        @(negedge clk);
        checkOutput("fw_valid", instr_valid, 1'b0);
        tick();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("fw_drop_valid", instr_valid, 1'b0);
            checkOutput("fw_drop_req", imem_req, 1'b0);
            tick();
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("fw_after_valid", instr_valid, 1'b0);
            checkOutput("fw_after_req", imem_req, 1'b0);
            tick();
        end
        applyStimulus('{32'h0000_0200, 32'h0010_0513, 0, 0, 0, 32'h0010_0513, 1'b0});

        // Redirect during the request phase with a slow grant.
        tick();
        pc       = 32'h0000_0400;
        fetch_en = 1'b1;
        tick();
        flush    = 1'b1;
        fetch_en = 1'b0;
        @(negedge clk);
        checkOutput("fr_req", imem_req, 1'b1);
        checkOutput("fr_stall", stall, 1'b0);
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("fr_req_held", imem_req, 1'b1);
            checkOutput("fr_addr_held", imem_addr, 32'h0000_0400);
            tick();
        end
        imem_gnt = 1'b1;
        @(negedge clk);
        checkOutput("fr_req_gnt", imem_req, 1'b1);
        tick();
        imem_gnt = 1'b0;
        @(negedge clk);
        checkOutput("fr_req_drop", imem_req, 1'b0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_BABE;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("fr_valid", instr_valid, 1'b0);
            checkOutput("fr_req_idle", imem_req, 1'b0);
            tick();
        end

        // Reset in the middle of a transaction, then a stray response.
        pc       = 32'h0000_0500;
        fetch_en = 1'b1;
        tick();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        fetch_en = 1'b0;
        @(negedge clk);
        checkOutput("mrst_req", imem_req, 1'b0);
        checkOutput("mrst_addr", imem_addr, 32'h0);
        checkOutput("mrst_instr", instr, NOP);
        checkOutput("mrst_instr_pc", instr_pc, 32'h0);
        checkOutput("mrst_fault", instr_fault, 1'b0);
        checkOutput("mrst_valid", instr_valid, 1'b0);
        checkOutput("mrst_stall", stall, 1'b0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("stray_valid", instr_valid, 1'b0);
            checkOutput("stray_req", imem_req, 1'b0);
            tick();
        end
        applyStimulus('{32'h0000_0600, 32'h0000_006F, 0, 0, 1, 32'h0000_006F, 1'b0});

        checkOutput("sb_empty", sb_queue.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
        $finish;
    end

endmodule
